jump_sequencer: RTL and testbench
=================================

JUMP_SEQUENCER -- requirements
Module: jump_sequencer

Interface
REQ-001 The module SHALL have parameter UUID, default 0, instance identifier XORed into sub-module UUIDs.
REQ-002 The module SHALL have parameter NAME, default "", instance label with no functional effect.
REQ-003 The module SHALL have parameter RESET_PC, default 0, 8-bit program-counter value loaded on reset.
REQ-004 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have port instr_valid  input  1  opcode/a/b/dest hold a fetched instruction this cycle.
REQ-007 The module SHALL have port opcode  input  8  LEG opcode byte; [7:6] immediate flags, already resolved upstream and ignored here.
REQ-008 The module SHALL have ports a and b  input  8 each  resolved comparison operands.
REQ-009 The module SHALL have port dest  input  8  jump target address.
REQ-010 The module SHALL have port stall  input  1  freeze all sequencer state this cycle.
REQ-011 The module SHALL have ports pc  output  8 (current fetch address), flush  output  1 (instruction presented this cycle is discarded), taken  output  1 (a jump was taken last active cycle), jump_count  output  8 (saturating count of taken jumps).

Function
REQ-012 Jump decode SHALL be opcode[5]=1 with opcode[3:0] in 0..5; opcode[4] is ignored, and opcode[5]=0 is never a jump.
REQ-013 Conditions SHALL be 0 a==b, 1 a!=b, 2 a<b, 3 a<=b, 4 a>b, 5 a>=b, all unsigned.
REQ-014 The FSM SHALL have exactly two states: RUN and FLUSH.
REQ-015 In RUN with stall=0, instr_valid=1, a jump opcode and a true condition: pc<=dest, taken<=1, jump_count increments saturating at 255, and the state goes to FLUSH.
REQ-016 In RUN with stall=0, instr_valid=1, and either a non-jump opcode or a false condition: pc<=pc+4 modulo 256 (252 wraps to 0), taken<=0.
REQ-017 In RUN with stall=0 and instr_valid=0: pc holds, taken<=0.
REQ-018 In FLUSH, flush SHALL be 1 combinationally; with stall=0, the presented instruction is ignored (pc holds, taken<=0) and the state returns to RUN after exactly one cycle.
REQ-019 With stall=1, pc, state, taken and jump_count SHALL all hold; flush reflects the held state.
REQ-020 Jump resolution latency SHALL be one cycle: pc equals dest on the cycle after the jump is accepted.
REQ-021 A jump whose dest equals the current pc SHALL still be taken and still enter FLUSH.

Reset
REQ-022 With rst=1 at a clock edge, the module SHALL set pc=RESET_PC, state=RUN, flush=0, taken=0 and jump_count=0.
REQ-023 rst SHALL take priority over stall, instr_valid and FLUSH, including reset arriving while in FLUSH.

Configuration
REQ-024 With macro JUMP_SEQUENCER_SIGNED_CMP_EN defined, opcode[3:0] 8..11 SHALL also be jumps: 8 a<b, 9 a<=b, 10 a>b, 11 a>=b, two's-complement signed.
REQ-025 Without JUMP_SEQUENCER_SIGNED_CMP_EN, opcode[3:0] 8..11 SHALL be non-jumps and advance pc by 4.
REQ-026 Opcode[3:0] values 6, 7 and 12..15 SHALL be non-jumps in both configurations.

Structure
REQ-027 A shared package SHALL hold: condition-code constants COND_EQ..COND_SGE, the FSM state enum {RUN, FLUSH}, INSTR_BYTES=4, and the opcode bit positions JUMP_FLAG_BIT=5 and the immediate-flag bits.
REQ-028 Condition evaluation SHALL sit in one combinational sub-module, jump_cond_eval (inputs opcode, a, b; output is_jump_taken), reused by any future branch predictor.
REQ-029 The top level SHALL contain only the FSM, the pc register and the counter.

Verification
REQ-030 Bench SHALL cover: reset, then 3 valid non-jumps (opcode 0x00) -> pc 0,4,8,12; flush=0; taken=0.
REQ-031 Bench SHALL cover: at pc=8, opcode 0x20, a=b=5, dest=0x40 -> next cycle pc=0x40, taken=1, flush=1; an instruction presented in FLUSH is ignored; pc stays 0x40 and then advances to 0x44.
REQ-032 Bench SHALL cover: opcode 0x22, a=200, b=3 -> not taken, pc+=4; opcode 0x2A, a=200, b=3 -> taken with SIGNED_CMP_EN, pc+=4 without it.
REQ-033 Bench SHALL cover: pc=252 with a non-jump -> pc=0; 256 taken jumps -> jump_count=255.
REQ-034 Bench SHALL cover: stall=1 asserted in FLUSH for 3 cycles -> flush stays 1 and pc is unchanged; after release, exactly one flush cycle.
REQ-035 Bench SHALL cover: rst=1 in FLUSH with stall=1 -> next cycle pc=RESET_PC, flush=0, jump_count=0.

Source files
------------

// File: rtl/jump_sequencer_pkg.sv
// Shared constants for the jump sequencer: condition codes, FSM states and opcode fields.
// The signed condition codes are only decoded when JUMP_SEQUENCER_SIGNED_CMP_EN is defined.
package jump_sequencer_pkg;

    localparam logic [3:0] COND_EQ  = 4'd0;
    localparam logic [3:0] COND_NE  = 4'd1;
    localparam logic [3:0] COND_LT  = 4'd2;
    localparam logic [3:0] COND_LE  = 4'd3;
    localparam logic [3:0] COND_GT  = 4'd4;
    localparam logic [3:0] COND_GE  = 4'd5;
    localparam logic [3:0] COND_SLT = 4'd8;
    localparam logic [3:0] COND_SLE = 4'd9;
    localparam logic [3:0] COND_SGT = 4'd10;
    localparam logic [3:0] COND_SGE = 4'd11;

    localparam logic [7:0] INSTR_BYTES = 8'd4;

    localparam int JUMP_FLAG_BIT = 5;
    localparam int IMM_A_BIT     = 7;
    localparam int IMM_B_BIT     = 6;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump decode and condition evaluation for LEG jump opcodes.
// Signed compares (codes 8..11) are enabled by JUMP_SEQUENCER_SIGNED_CMP_EN.
module jump_cond_eval
    import jump_sequencer_pkg::*;
#(
    parameter int UUID = 0
) (
    input  logic [7:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       is_jump_taken
);

    // Immediate flags are resolved upstream and bit 4 carries no meaning for jumps.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^{opcode[IMM_A_BIT], opcode[IMM_B_BIT], opcode[4], UUID[0]};

    always_comb begin
        is_jump_taken = 1'b0;
        if (opcode[JUMP_FLAG_BIT]) begin
            case (opcode[3:0])
                COND_EQ:  is_jump_taken = (a == b);
                COND_NE:  is_jump_taken = (a != b);
                COND_LT:  is_jump_taken = (a <  b);
                COND_LE:  is_jump_taken = (a <= b);
                COND_GT:  is_jump_taken = (a >  b);
                COND_GE:  is_jump_taken = (a >= b);
`ifdef JUMP_SEQUENCER_SIGNED_CMP_EN
                COND_SLT: is_jump_taken = ($signed(a) <  $signed(b));
                COND_SLE: is_jump_taken = ($signed(a) <= $signed(b));
                COND_SGT: is_jump_taken = ($signed(a) >  $signed(b));
                COND_SGE: is_jump_taken = ($signed(a) >= $signed(b));
`else
`endif
                default:  is_jump_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/jump_sequencer.sv
// Program-counter sequencer: one-cycle jump resolution with a single flush slot after taken jumps.
// Optional signed conditions come from JUMP_SEQUENCER_SIGNED_CMP_EN (see jump_cond_eval).
module jump_sequencer
    import jump_sequencer_pkg::*;
#(
    parameter int         UUID     = 0,
    parameter             NAME     = "",
    parameter logic [7:0] RESET_PC = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] dest,
    input  logic       stall,
    output logic [7:0] pc,
    output logic       flush,
    output logic       taken,
    output logic [7:0] jump_count
);

    localparam int UUID_COND = UUID ^ 1;
    localparam int unused_name_len = $bits(NAME);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       taken_q, taken_d;
    logic [7:0] count_q, count_d;
    logic       is_jump_taken;

    jump_cond_eval #(
        .UUID (UUID_COND)
    ) u_cond (
        .opcode        (opcode),
        .a             (a),
        .b             (b),
        .is_jump_taken (is_jump_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        count_d = count_q;
        if (!stall) begin
            taken_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (instr_valid) begin
                        if (is_jump_taken) begin
                            pc_d    = dest;
                            taken_d = 1'b1;
                            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                            state_d = FLUSH;
                        end else begin
                            pc_d = pc_q + INSTR_BYTES;
                        end
                    end
                end
                // The instruction fetched behind a taken jump is dropped here.
                FLUSH: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    assign pc         = pc_q;
    assign flush      = (state_q == FLUSH);
    assign taken      = taken_q;
    assign jump_count = count_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// Scoreboard bench for jump_sequencer: driver queues expected post-edge state, monitor checks it.
module tb_jump_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic [7:0] dest = 8'h00;
    logic       stall = 1'b0;
    logic [7:0] pc;
    logic       flush;
    logic       taken;
    logic [7:0] jump_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] pc;
        logic       flush;
        logic       taken;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    jump_sequencer #(
        .UUID     (0),
        .NAME     ("tb"),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .dest        (dest),
        .stall       (stall),
        .pc          (pc),
        .flush       (flush),
        .taken       (taken),
        .jump_count  (jump_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%02h expected 0x%02h at %0t", nm, field, act, exp, $time);
        end
    endtask

    // Monitor: state registered at each edge is compared against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "pc",    pc,                e.pc);
            chk(e.name, "flush", {7'd0, flush},     {7'd0, e.flush});
            chk(e.name, "taken", {7'd0, taken},     {7'd0, e.taken});
            chk(e.name, "count", jump_count,        e.cnt);
        end
    end

    task automatic step(input logic r, input logic s, input logic v, input logic [7:0] op,
                        input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] dd,
                        input logic [7:0] epc, input logic efl, input logic etk,
                        input logic [7:0] ecnt, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; instr_valid = v; opcode = op; a = aa; b = bb; dest = dd;
        e.pc = epc; e.flush = efl; e.taken = etk; e.cnt = ecnt; e.name = nm;
        exp_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        logic [7:0] p;
        // reset and three sequential non-jumps
        step(1, 0, 0, 8'h00, 0, 0, 0,      8'h00, 0, 0, 8'd0, "reset");
        step(0, 0, 1, 8'h00, 1, 2, 8'h80,  8'h04, 0, 0, 8'd0, "seq0");
        step(0, 0, 1, 8'h00, 5, 5, 8'h80,  8'h08, 0, 0, 8'd0, "seq1");
        step(0, 0, 1, 8'h00, 0, 0, 8'h80,  8'h0C, 0, 0, 8'd0, "seq2");
        // back to pc=8, then a taken equality jump
        step(1, 0, 0, 8'h00, 0, 0, 0,      8'h00, 0, 0, 8'd0, "reset2");
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h04, 0, 0, 8'd0, "seq3");
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h08, 0, 0, 8'd0, "seq4");
        step(0, 0, 1, 8'h20, 5, 5, 8'h40,  8'h40, 1, 1, 8'd1, "jeq");
        step(0, 0, 1, 8'h20, 7, 7, 8'h80,  8'h40, 0, 0, 8'd1, "flush_ign");
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h44, 0, 0, 8'd1, "after_fl");
        // unsigned vs signed less-than
        step(0, 0, 1, 8'h22, 200, 3, 8'h10, 8'h48, 0, 0, 8'd1, "ult_f");
`ifdef JUMP_SEQUENCER_SIGNED_CMP_EN
        step(0, 0, 1, 8'h2A, 200, 3, 8'h10, 8'h10, 1, 1, 8'd2, "slt");
        step(0, 0, 0, 8'h00, 0, 0, 0,       8'h10, 0, 0, 8'd2, "slt_fl");
        c = 8'd2;
`else
        step(0, 0, 1, 8'h2A, 200, 3, 8'h10, 8'h4C, 0, 0, 8'd1, "slt_off");
        step(0, 0, 0, 8'h00, 0, 0, 0,       8'h4C, 0, 0, 8'd1, "idle");
        c = 8'd1;
`endif
        // other conditions and decode corners
        step(0, 0, 1, 8'h21, 1, 2, 8'h30,  8'h30, 1, 1, c + 8'd1, "jne"); c++;
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h30, 0, 0, c, "jne_fl");
        step(0, 0, 1, 8'h25, 2, 3, 8'h90,  8'h34, 0, 0, c, "jge_f");
        step(0, 0, 1, 8'h26, 3, 3, 8'h90,  8'h38, 0, 0, c, "cond6");
        step(0, 0, 1, 8'h0C, 3, 3, 8'h90,  8'h3C, 0, 0, c, "nojflag");
        step(0, 0, 1, 8'h24, 4, 3, 8'h50,  8'h50, 1, 1, c + 8'd1, "jgt"); c++;
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h50, 0, 0, c, "jgt_fl");
        step(0, 0, 1, 8'h33, 3, 3, 8'h60,  8'h60, 1, 1, c + 8'd1, "jle_b4"); c++;
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h60, 0, 0, c, "jle_fl");
        step(0, 0, 0, 8'h20, 0, 0, 8'h99,  8'h60, 0, 0, c, "invalid");
        // wrap at 252, then a jump to its own pc
        step(0, 0, 1, 8'h20, 0, 0, 8'hFC,  8'hFC, 1, 1, c + 8'd1, "to252"); c++;
        step(0, 0, 0, 8'h00, 0, 0, 0,      8'hFC, 0, 0, c, "to252_fl");
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h00, 0, 0, c, "wrap");
        step(0, 0, 1, 8'h20, 9, 9, 8'h00,  8'h00, 1, 1, c + 8'd1, "self"); c++;
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h00, 0, 0, c, "self_fl");
        // stall while in FLUSH
        step(0, 0, 1, 8'h20, 1, 1, 8'h20,  8'h20, 1, 1, c + 8'd1, "j20"); c++;
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 8'h20, 1, 1, 8'h70, 8'h20, 1, 1, c, "stall_fl");
        step(0, 0, 1, 8'h20, 1, 1, 8'h70,  8'h20, 0, 0, c, "release");
        step(0, 0, 1, 8'h00, 0, 0, 0,      8'h24, 0, 0, c, "post_rel");
        // counter saturation
        for (int i = 0; i < 256; i++) begin
            p = 8'(i * 4);
            c = (c == 8'hFF) ? c : c + 8'd1;
            step(0, 0, 1, 8'h20, 0, 0, p,  p, 1, 1, c, "sat_j");
            step(0, 0, 0, 8'h00, 0, 0, 0,  p, 0, 0, c, "sat_fl");
        end
        step(0, 0, 1, 8'h21, 0, 1, 8'h60,  8'h60, 1, 1, 8'hFF, "sat_hold");
        // reset wins over stall while in FLUSH
        step(1, 1, 1, 8'h20, 0, 0, 8'h11,  8'h00, 0, 0, 8'd0, "rst_fl");
        step(0, 0, 0, 8'h00, 0, 0, 0,      8'h00, 0, 0, 8'd0, "post_rst");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
